// File: rtl/encode_pkg.sv
// encode_pkg: header constants and encoding helpers shared by the packetizer.
package encode_pkg;
  localparam logic [2:0] HDR_3OF6 = 3'b001;
  localparam logic [2:0] HDR_CHK = 3'b010;
  localparam int NX_MAX = 1024;
  function automatic logic [5:0] enc3of6(input logic [2:0] v);
    case (v)
      3'd0: enc3of6 = 6'b000111;
      3'd1: enc3of6 = 6'b001011;
      3'd2: enc3of6 = 6'b001101;
      3'd3: enc3of6 = 6'b001110;
      3'd4: enc3of6 = 6'b010011;
      3'd5: enc3of6 = 6'b010101;
      3'd6: enc3of6 = 6'b010110;
      default: enc3of6 = 6'b011001;
    endcase
  endfunction
  // Fixed-bound loop keeps this synthesizable; callers zero-extend to NX_MAX bits.
  function automatic logic [3:0] nibble_xor(input logic [NX_MAX-1:0] v, input int n);
    nibble_xor = '0;
    for (int i = 0; i < NX_MAX / 4; i++)
      if (i < n) nibble_xor ^= v[4*i+:4];
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-2 depth FIFO with occupancy count and full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/encode_packetizer.sv
// encode_packetizer: buffers node packets and emits 3-of-6 or checksummed router packets.
module encode_packetizer
  import encode_pkg::*;
#(
  parameter int PAYLOAD_W = 24,
  parameter int ADDR_W = 4,
  parameter int DEPTH = 4,
  localparam int PKT_W = 3 + ADDR_W + 2 * PAYLOAD_W,
  localparam int IN_W = 1 + ADDR_W + PAYLOAD_W,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_pkt,
  output logic [CW-1:0]    fifo_count,
  output logic [15:0]      pkt_count
);
  logic [IN_W-1:0] head;
  logic [2*PAYLOAD_W-1:0] code;
  logic [PKT_W-1:0] enc;
  logic full, empty, load;
  // Ready depends only on occupancy so out_ready never reaches in_ready.
  assign in_ready = !full;
  assign load = !empty && (!out_valid || out_ready);
  sync_fifo #(.WIDTH(IN_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(in_valid),
    .pop(load),
    .din(in_pkt),
    .dout(head),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    code = '0;
    for (int i = 0; i < PAYLOAD_W / 3; i++) code[6*i+:6] = enc3of6(head[3*i+:3]);
  end
  assign enc = head[IN_W-1]
    ? {HDR_3OF6, head[PAYLOAD_W+:ADDR_W], code}
    : {HDR_CHK, head[PAYLOAD_W+:ADDR_W], head[PAYLOAD_W-1:0],
       nibble_xor(NX_MAX'(head[PAYLOAD_W-1:0]), PAYLOAD_W / 4), {(PAYLOAD_W-4){1'b0}}};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pkt <= '0;
      pkt_count <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_pkt <= enc;
      end else if (out_ready) out_valid <= 1'b0;
      if (out_valid && out_ready && pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
    end
endmodule
